// File: rtl/radix2_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// producing one quotient bit per clock with registered results and status flags.
module radix2_divider #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 q_ovf
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [DW-1:0]     shift_q, shift_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic              zpend_q, zpend_d;
  logic [WIDTH-1:0]  zlow_q, zlow_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DW-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]  rmdr_q, rmdr_d;
  logic              dbz_q, dbz_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH:0]    trial;
  logic              fits;
  logic [WIDTH-1:0]  step_rem;
  logic [DW-1:0]     step_acc;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    trial    = {rem_q, shift_q[DW-1]};
    fits     = (trial >= {1'b0, dvs_q});
    step_rem = fits ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
    step_acc = {acc_q[DW-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    zpend_d = zpend_q;
    zlow_d  = zlow_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rmdr_d  = rmdr_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        // A zero-divisor request completes one edge after it was accepted.
        if (zpend_q) begin
          quot_d  = '1;
          rmdr_d  = zlow_q;
          dbz_d   = 1'b1;
          ovf_d   = 1'b1;
          done_d  = 1'b1;
          zpend_d = 1'b0;
        end
        if (start) begin
          if (divisor != '0) begin
            shift_d = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            acc_d   = '0;
            count_d = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            zpend_d = 1'b1;
            zlow_d  = dividend[WIDTH-1:0];
          end
        end
      end
      RUN: begin
        rem_d   = step_rem;
        shift_d = {shift_q[DW-2:0], 1'b0};
        acc_d   = step_acc;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          quot_d  = step_acc;
          rmdr_d  = step_rem;
          dbz_d   = 1'b0;
          ovf_d   = |step_acc[DW-1:WIDTH];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      zpend_q <= 1'b0;
      zlow_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rmdr_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      zpend_q <= zpend_d;
      zlow_q  <= zlow_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rmdr_q  <= rmdr_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rmdr_q;
  assign div_by_zero = dbz_q;
  assign q_ovf       = ovf_q;

endmodule

// File: doc/radix2_divider.md
# radix2_divider

Sequential restoring divider: divides a 2·WIDTH-bit dividend by a WIDTH-bit divisor, producing a 2·WIDTH-bit quotient and a WIDTH-bit remainder at one quotient bit per clock. It is the inverse of the 16x16 Dadda multiplier. Its main use is a self-check path: divide a product P by one operand B and require quotient = A and remainder = 0. It also serves as a general-purpose divider on the datapath.

## Interface
Parameters:
- WIDTH, 16, divisor/remainder width; dividend and quotient are 2·WIDTH bits

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  request; sampled only while busy=0
- dividend  input  2·WIDTH  numerator; captured on the accepting edge
- divisor  input  WIDTH  denominator; captured on the accepting edge
- busy  output  1  high while a division is in progress
- done  output  1  single-cycle pulse; results valid
- quotient  output  2·WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_by_zero  output  1  registered; the last operation had divisor = 0
- q_ovf  output  1  registered; quotient does not fit in WIDTH bits (|quotient[2·WIDTH-1:WIDTH])

## Operation
- States: IDLE, RUN.
- IDLE:
  - start=1 and divisor≠0: capture operands, clear partial remainder and iteration counter, set busy=1, go to RUN.
  - start=1 and divisor=0: no iterations. Next edge: quotient=all ones, remainder=dividend[WIDTH-1:0], div_by_zero=1, q_ovf=1, done=1. Stay in IDLE.
- RUN: one step per cycle, 2·WIDTH steps, counter 0..2·WIDTH-1.
  - Partial remainder R is WIDTH+1 bits.
  - Each step: R' = {R[WIDTH-1:0], dividend_shift MSB}; shift dividend_shift left by 1.
  - If R' ≥ {1'b0, divisor}: R = R' − divisor and shift 1 into the quotient LSB. Otherwise R = R' and shift 0 in.
  - On the final step (counter = 2·WIDTH-1):
    - load the quotient and remainder outputs, R[WIDTH-1:0] into remainder;
    - div_by_zero=0; q_ovf from the final quotient;
    - done=1, busy=0; return to IDLE.
- Output registers quotient/remainder/div_by_zero/q_ovf change only on completion and hold until the next completion.
- start while busy=1 is ignored. No queuing, no error flag; operand inputs are don't-care.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset value of every output: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, q_ovf=0. State is IDLE, counter=0.
- Edge numbering below is relative to the start-accepting edge, called edge 0.
- Normal division:
  - busy=1 after edge 0.
  - Iterations occur on edges 1..2·WIDTH (32 for WIDTH=16).
  - After edge 2·WIDTH: done=1, busy=0, results valid. Latency is 2·WIDTH cycles.
- Divide by zero: done=1 after edge 1. busy stays 0 throughout.
- done is high for exactly one cycle and deasserts on the following edge unless another completion occurs on that edge.
- Back-to-back: start may be accepted on the edge at which done is high, i.e. the first edge with busy=0. No dead cycles.
- Reset takes priority over everything. rst_n=0 mid-RUN aborts on that edge: all outputs return to reset values and no done is produced. The aborted result is discarded.
- Reset and start on the same edge: reset wins; start is not accepted.
- Dividend < divisor: quotient=0, remainder=dividend, full 2·WIDTH latency (no early exit).

## Test plan
- 0xFFFE0001 / 0xFFFF → quotient=0x0000FFFF, remainder=0x0000, q_ovf=0, div_by_zero=0. done exactly 32 cycles after the start edge, busy high for those 32 cycles.
- 100 / 7 → quotient=14, remainder=2. Then 5 / 9 → quotient=0, remainder=5. Second start issued in the done cycle: second done exactly 32 cycles after it.
- 0x12345678 / 0 → div_by_zero=1, q_ovf=1, quotient=0xFFFFFFFF, remainder=0x5678, done one cycle after start, busy never asserted.
- 0x00010000 / 1 → quotient=0x00010000, remainder=0, q_ovf=1. Then 0xFFFFFFFF / 0xFFFF → quotient=0x00010001, remainder=0, q_ovf=1.
- Start 1000/3. Pulse start with 9/9 at cycle 10 (ignored). Then rst_n=0 for one cycle at cycle 20 → all outputs 0, no done. Next start 9/9 → quotient=1, remainder=0 after 32 cycles.
- Multiplier loopback: random A, B≠0 (≥1000 pairs); feed the Dadda product P with divisor B → quotient=A, remainder=0, q_ovf=0 every time.
